// File: rtl/counter_pkg.sv
// Shared definitions for the synchronous down counter: FSM state encoding and
// a small helper used when deciding where a load sends the FSM.
package counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // A zero load value means there is nothing to count, so go straight to DONE.
  function automatic state_t load_target(input logic nonzero);
    return nonzero ? ST_RUN : ST_DONE;
  endfunction

endpackage

// File: rtl/sync_tff_ld.sv
// One counter bit: synchronous T flip-flop with parallel load.
// Priority is rst > ld > t.
module sync_tff_ld (
  input  logic clk,
  input  logic rst,
  input  logic t,
  input  logic ld,
  input  logic d,
  output logic q
);

  // NOTE: sequential state is written with non-blocking assignments so that every
  // flop samples the pre-edge values of its neighbours, regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else if (ld) begin
      q <= d;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/sync_down_counter.sv
// Loadable synchronous down counter / one-shot timer with optional auto-reload.
// Bits are T flops driven by a borrow chain; the FSM and tc register live here.
module sync_down_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [WIDTH-1:0] reload_reg;
  logic [WIDTH-1:0] borrow;
  logic [WIDTH-1:0] d;
  logic             ld;
  logic             at_one;
  logic             step;
  logic             expire;
  logic             dec;

  assign at_one = (count == WIDTH'(1));
  assign step   = (state == ST_RUN) && en && !load;
  assign expire = step && at_one;
  // The 1 -> next transition is handled by a load, so the chain never sees 0 and
  // the counter cannot wrap to all-ones.
  assign dec    = step && !at_one;

  // NOTE: every signal assigned here gets a value on every path (defaults first),
  // otherwise synthesis would infer latches.
  always_comb begin
    borrow    = '0;
    borrow[0] = dec;
    for (int i = 1; i < WIDTH; i++) begin
      borrow[i] = borrow[i-1] & ~count[i-1];
    end
  end

  always_comb begin
    ld = load | expire;
    if (load) begin
      d = load_val;
    end else if (auto_reload) begin
      d = reload_reg;
    end else begin
      d = '0;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sync_tff_ld u_bit (
      .clk (clk),
      .rst (rst),
      .t   (borrow[i]),
      .ld  (ld),
      .d   (d[i]),
      .q   (count[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      reload_reg <= '0;
      tc         <= 1'b0;
    end else if (load) begin
      state      <= load_target(load_val != '0);
      reload_reg <= load_val;
      tc         <= 1'b0;
    end else begin
      tc <= 1'b0;
      case (state)
        ST_RUN: begin
          if (en && at_one) begin
            tc    <= 1'b1;
            state <= auto_reload ? ST_RUN : ST_DONE;
          end
        end
        ST_DONE: state <= ST_DONE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule
